// File: rtl/alu_pkg.sv
// Shared select encoding for the ALU B-operand stage.
// Values above SEL_LAST are illegal and produce a zero operand.
package alu_pkg;

    typedef enum logic [2:0] {
        SEL_REG_B     = 3'd0,
        SEL_PC_INC    = 3'd1,
        SEL_IMM_SEXT  = 3'd2,
        SEL_IMM_SHL   = 3'd3,
        SEL_IMM_ZEXT  = 3'd4,
        SEL_IMM_UPPER = 3'd5
    } alu_src_b_e;

    localparam logic [2:0] SEL_LAST = 3'd5;

endpackage

// File: rtl/alu_operand_b_stage_chk.sv
// Handshake invariants for the operand stage: no push when full, no pop when empty,
// head operand stable while the consumer stalls.
module alu_operand_b_stage_chk #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic                       clock,
    input logic                       reset,
    input logic                       in_valid,
    input logic                       in_ready,
    input logic                       out_valid,
    input logic                       out_ready,
    input logic [WIDTH-1:0]           operand,
    input logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             hold_r;
    logic [WIDTH-1:0] operand_prev_r;

    // Remember whether the previous edge was a stall and what the head was then.
    always_ff @(posedge clock) begin
        hold_r         <= !reset && out_valid && !out_ready;
        operand_prev_r <= operand;
    end

    // Invariant checks sampled on each rising edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(in_valid && in_ready && (count == CNT_W'(DEPTH))));
            assert (!(out_valid && out_ready && (count == CNT_W'(0))));
            if (hold_r) begin
                assert (operand == operand_prev_r);
            end
        end
    end

endmodule

// File: rtl/operand_fifo.sv
// Small valid/ready operand buffer.
// The head entry is kept in its own register so that the read data is a registered output.
module operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = in_valid && in_ready_r;
    assign pop_s     = out_valid_r && out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign rdata     = head_r;
    assign count     = count_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Next head: the incoming word when it lands at the front, else the successor on a pop.
    always_comb begin
        head_next_s = head_r;
        if (push_s && ((count_r == CNT_W'(0)) || ((count_r == CNT_W'(1)) && pop_s))) begin
            head_next_s = wdata;
        end else if (pop_s && (count_r > CNT_W'(1))) begin
            head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            head_r      <= WIDTH'(0);
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_next_s;
            head_r      <= head_next_s;
            in_ready_r  <= (count_next_s != CNT_W'(DEPTH));
            out_valid_r <= (count_next_s != CNT_W'(0));
        end
    end

endmodule

// File: rtl/alu_operand_b_stage.sv
// ALU B-operand select: forms the operand from reg B, a PC increment or the immediate,
// then buffers it behind a valid/ready handshake.
module alu_operand_b_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4,
    parameter int SHAMT  = 2,
    parameter int DEPTH  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [15:0]      imm16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand,
    output logic             sel_err
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]    imm_sext_s;
    logic [WIDTH+31:0]   imm_upper_wide_s;
    logic [WIDTH-1:0]    operand_s;
    logic                sel_illegal_s;
    logic                accept_s;
    logic                sel_err_r;
    logic                fifo_in_ready_s;
    logic                fifo_out_valid_s;
    logic [WIDTH-1:0]    fifo_rdata_s;
    logic [CNT_W-1:0]    fifo_count_s;

    assign imm_sext_s       = {{(WIDTH-16){imm16[15]}}, imm16};
    // Built wide and truncated so narrow widths keep the low bits and wide ones sign-extend.
    assign imm_upper_wide_s = {{WIDTH{imm16[15]}}, imm16, 16'h0000};
    assign sel_illegal_s    = (sel > SEL_LAST);
    assign accept_s         = in_valid && fifo_in_ready_s;

    // Operand formation from the select.
    always_comb begin
        operand_s = WIDTH'(0);
        case (sel)
            SEL_REG_B:     operand_s = reg_b;
            SEL_PC_INC:    operand_s = WIDTH'(PC_INC);
            SEL_IMM_SEXT:  operand_s = imm_sext_s;
            SEL_IMM_SHL:   operand_s = imm_sext_s << SHAMT;
            SEL_IMM_ZEXT:  operand_s = {{(WIDTH-16){1'b0}}, imm16};
            SEL_IMM_UPPER: operand_s = imm_upper_wide_s[WIDTH-1:0];
            default:       operand_s = WIDTH'(0);
        endcase
    end

    // Sticky illegal-select flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && sel_illegal_s) begin
            sel_err_r <= 1'b1;
        end
    end

    operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (fifo_in_ready_s),
        .wdata     (operand_s),
        .out_valid (fifo_out_valid_s),
        .out_ready (out_ready),
        .rdata     (fifo_rdata_s),
        .count     (fifo_count_s)
    );

    alu_operand_b_stage_chk #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chk (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (fifo_in_ready_s),
        .out_valid (fifo_out_valid_s),
        .out_ready (out_ready),
        .operand   (fifo_rdata_s),
        .count     (fifo_count_s)
    );

    assign in_ready  = fifo_in_ready_s;
    assign out_valid = fifo_out_valid_s;
    assign operand   = fifo_rdata_s;
    assign sel_err   = sel_err_r;

endmodule
